// File: rtl/timer_bank_if.sv
// timer_bank_if: control/status bundle for the timer bank.
//   ct, en, periodic : per-channel restart, count enable and auto-reload mode
//   load_val         : per-channel reload value, channel i at [i*WIDTH +: WIDTH]
//   t                : one-cycle expiry pulse per channel
//   done             : sticky expiry flag per channel
//   count            : current per-channel count, same packing as load_val
// master = the controller driving the timers, slave = timer_bank.
interface timer_bank_if #(
  parameter int WIDTH    = 11,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]       ct;
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS-1:0]       periodic;
  logic [CHANNELS*WIDTH-1:0] load_val;
  logic [CHANNELS-1:0]       t;
  logic [CHANNELS-1:0]       done;
  logic [CHANNELS*WIDTH-1:0] count;

  modport master (output ct, en, periodic, load_val, input  t, done, count);
  modport slave  (input  ct, en, periodic, load_val, output t, done, count);
endinterface

// File: rtl/timer_bank.sv
// timer_bank: CHANNELS independent countdown timers sharing one tick prescaler.
//   tclk_i : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : timer_bank_if slave (ct/en/periodic/load_val in, t/done/count out)
// A channel loaded with L expires every L+1 ticks; tick fires once every
// PRESCALE cycles (every cycle for PRESCALE=1).

// One timer channel: IDLE -> RUN on ct; RUN expires at count==0 and either
// reloads (periodic) or parks in DONE.
module timer_bank_ch #(
  parameter int               WIDTH   = 11,
  parameter logic [WIDTH-1:0] RST_CNT = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             ct_i,
  input  logic             en_i,
  input  logic             periodic_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             t_o,
  output logic             done_o,
  output logic [WIDTH-1:0] count_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             t_q, t_d, done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= RST_CNT;
      t_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      t_q     <= t_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    t_d     = 1'b0;
    done_d  = done_q;
    if (ct_i) begin
      // Restart wins over a same-edge expiry, so that pulse is swallowed.
      state_d = S_RUN;
      count_d = load_val_i;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (tick_i && en_i) begin
            if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end else begin
              t_d    = 1'b1;
              done_d = 1'b1;
              // The reload edge is the first tick of the next period.
              if (periodic_i) count_d = load_val_i;
              else            state_d = S_DONE;
            end
          end
        end
        default: ;  // IDLE and DONE hold until ct
      endcase
    end
  end

  assign t_o     = t_q;
  assign done_o  = done_q;
  assign count_o = count_q;
endmodule

module timer_bank #(
  parameter int WIDTH          = 11,
  parameter int CHANNELS       = 4,
  parameter int RELOAD_DEFAULT = 1800,
  parameter int PRESCALE       = 1
) (
  input  logic         tclk_i,
  input  logic         rst_i,
  timer_bank_if.slave  bus
);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RELOAD_DEFAULT);
  localparam logic [15:0]      PS_MAX  = 16'(PRESCALE - 1);

  // Free-running prescaler; only rst realigns it, ct does not.
  logic [15:0] psc_q, psc_d;
  logic        tick;

  assign tick  = (psc_q == PS_MAX);
  assign psc_d = tick ? 16'd0 : psc_q + 16'd1;

  always_ff @(posedge tclk_i) begin
    if (rst_i) psc_q <= 16'd0;
    else       psc_q <= psc_d;
  end

  logic [CHANNELS-1:0][WIDTH-1:0] load_w, count_w;
  logic [CHANNELS-1:0]            t_w, done_w;

  assign load_w    = bus.load_val;
  assign bus.count = count_w;
  assign bus.t     = t_w;
  assign bus.done  = done_w;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    timer_bank_ch #(.WIDTH(WIDTH), .RST_CNT(RST_CNT)) u_ch (
      .clk_i      (tclk_i),
      .rst_i      (rst_i),
      .tick_i     (tick),
      .ct_i       (bus.ct[g]),
      .en_i       (bus.en[g]),
      .periodic_i (bus.periodic[g]),
      .load_val_i (load_w[g]),
      .t_o        (t_w[g]),
      .done_o     (done_w[g]),
      .count_o    (count_w[g])
    );
  end
endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel countdown timer bank, the successor to the single-channel phase timer in the DP3 controller. It provides CHANNELS independent down-counters. Each channel has its own restart, enable, reload value and one-shot/periodic mode, and all channels share a common tick prescaler. The controller FSM uses it to time light phases, with one channel per phase or per intersection.

## Interface
Parameters:
- WIDTH, 11: counter width per channel.
- CHANNELS, 4: number of independent channels.
- RELOAD_DEFAULT, 1800: count value loaded into every channel at reset.
- PRESCALE, 1: number of tclk cycles per count tick; legal range 1..65535.

Ports:
- tclk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ct  in  CHANNELS  per-channel restart: load load_val and start running.
- en  in  CHANNELS  per-channel count enable; 0 pauses the channel.
- periodic  in  CHANNELS  per-channel mode: 1 auto-reloads on expiry, 0 is one-shot.
- load_val  in  CHANNELS*WIDTH  per-channel reload value; channel i occupies bits [i*WIDTH +: WIDTH].
- t  out  CHANNELS  expiry pulse, one tclk cycle wide, registered.
- done  out  CHANNELS  sticky expiry flag, cleared by ct or rst.
- count  out  CHANNELS*WIDTH  current per-channel count, registered.

## Operation
- Prescaler:
  - Shared counter runs 0..PRESCALE-1 and wraps.
  - tick = (prescaler == PRESCALE-1). With PRESCALE=1, tick is asserted every cycle.
  - The prescaler is reset only by rst; ct does not reset it.
- Per-channel FSM states: IDLE, RUN, DONE.
- Reset:
  - Every channel enters IDLE.
  - count = RELOAD_DEFAULT, t = 0, done = 0, prescaler = 0.
- Priority per channel, per edge: rst > ct > expiry/decrement.
- ct=1, any state:
  - count <= load_val, done <= 0, t <= 0; state goes to RUN.
  - A ct coinciding with an expiry suppresses that t pulse.
- IDLE: count holds and en is ignored. The only exit is ct.
- RUN with tick=1 and en=1:
  - If count != 0: count <= count-1.
  - If count == 0: t <= 1 and done <= 1. Then:
    - periodic=1: count <= load_val (sampled at this edge) and the channel stays in RUN.
    - periodic=0: count holds at 0 and the channel goes to DONE.
- RUN with tick=0 or en=0: count holds and t <= 0.
- DONE: count holds at 0 and done holds at 1. The only exit is ct.
- In every cycle without an expiry, t <= 0.
- Arithmetic:
  - Unsigned WIDTH-bit arithmetic.
  - The decrement never wraps, because the count==0 case is handled before it.
  - load_val = 0 is legal: the channel expires on its first tick. With periodic=1 it then pulses t on every tick.
- Changing periodic while in RUN takes effect at the next expiry.
- Changing load_val while in RUN affects only the next reload.

## Timing
- Latency:
  - ct sampled at edge E0 makes count = L visible after E0.
  - With en=1 and PRESCALE=1, count reaches 0 after edge E0+L.
  - t is high for the single cycle following edge E0+L+1.
  - Expiry period is therefore (L+1) ticks, i.e. (L+1)*PRESCALE tclk cycles after tick alignment.
- Periodic mode: expiries occur every (L+1) ticks with no dead cycle, so the reload tick counts as the first tick of the new period.
- done rises in the same cycle as the first t pulse.
- Channels are fully independent. Simultaneous expiries on several channels each produce their own t pulse.
- rst asserted mid-count returns all outputs to their reset values at the next edge, regardless of ct or en.

## Test plan
1. **Reset values.** Assert rst for 2 cycles → every count = 1800, t = 0, done = 0; a channel left without ct never decrements.
2. **One-shot.** PRESCALE=1, ch0: load_val=5, periodic=0, en=1, ct pulsed at E0 → count runs 5,4,3,2,1,0; t high exactly in the cycle after E0+6; done=1; count stays 0 and no further t pulses over the next 20 cycles.
3. **Periodic and zero reload.**
   - ch1: load_val=3, periodic=1 → t pulses every 4 cycles, done sticks at 1, count reloads to 3.
   - Then load_val=0 → t is high every cycle.
4. **Pause.** ch2: load_val=10; drop en to 0 for 7 cycles mid-count → count frozen for those 7 cycles; expiry delayed by exactly 7 cycles; no t pulse while paused.
5. **Prescaler.** PRESCALE=4, load_val=2, periodic=1 → t period is 12 tclk cycles; count changes only on tick cycles.
6. **Collisions and mid-run reset.**
   - ct asserted in the same cycle as the count==0 expiry edge → no t pulse, done=0, count=load_val.
   - rst asserted while channels are running → next cycle all counts are 1800, all t = 0, all done = 0.
